// File: rtl/frame_pkg.sv
// Shared types and defaults for the frame scheduler: FSM states, header magic,
// default geometry and the frame index width helper.
package frame_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      DATA   = 2'd2
   } state_t;

   localparam logic [15:0] MAGIC_DEF  = 16'hA5A5;
   localparam int          N_CH_DEF   = 8;
   localparam int          DATA_W_DEF = 32;

   // A single-channel frame would still need a one-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/channel_hold.sv
// One channel's latest-sample register and fresh flag. The snapshot output
// bypasses a same-cycle strobe so a frame never misses the newest sample.
module channel_hold #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              snap_clr,
   output logic [DATA_W-1:0] snap_data,
   output logic              fresh
);

   logic [DATA_W-1:0] hold_q;

   // A strobe landing in the snapshot cycle belongs to the frame being taken,
   // so the clear wins over the set.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_q <= '0;
         fresh  <= 1'b0;
      end else begin
         if (sample_valid) hold_q <= sample_data;
         if (snap_clr)          fresh <= 1'b0;
         else if (sample_valid) fresh <= 1'b1;
      end
   end

   assign snap_data = sample_valid ? sample_data : hold_q;

endmodule

// File: rtl/frame_scheduler.sv
// Snapshots N_CH channel samples on a trigger and streams a header plus N_CH
// data words over valid/ready, counting completed frames and dropped triggers.
//
// state  | meaning
// IDLE   | waiting for enable_i & trigger_i; snapshot taken on acceptance
// HEADER | presenting {MAGIC, frame count[15:0]}
// DATA   | presenting frame_buf[idx]; last word ends the frame
module frame_scheduler
   import frame_pkg::*;
#(
   parameter int          N_CH   = N_CH_DEF,
   parameter int          DATA_W = DATA_W_DEF,
   parameter logic [15:0] MAGIC  = MAGIC_DEF
) (
   input  logic                   clk,
   input  logic                   rst_ni,
   input  logic                   enable_i,
   input  logic                   trigger_i,
   input  logic [N_CH*DATA_W-1:0] ch_data_i,
   input  logic [N_CH-1:0]        ch_valid_i,
   output logic [DATA_W-1:0]      m_data_o,
   output logic                   m_valid_o,
   output logic                   m_last_o,
   input  logic                   m_ready_i,
   output logic [DATA_W-1:0]      osync_o,
   output logic                   busy_o,
   output logic [15:0]            overrun_cnt_o,
   output logic [N_CH-1:0]        stale_mask_o
);

   localparam int IDX_W = idx_w(N_CH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] osync_d, data_d;
   logic              valid_d, last_d;
   logic              accept;
   logic [DATA_W-1:0] snap_data [N_CH];
   logic [DATA_W-1:0] frame_buf [N_CH];
   logic [N_CH-1:0]   fresh;

   assign accept = (state_q == IDLE) && enable_i && trigger_i;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      channel_hold #(.DATA_W(DATA_W)) u_hold (
         .clk          (clk),
         .rst_ni       (rst_ni),
         .sample_valid (ch_valid_i[k]),
         .sample_data  (ch_data_i[k*DATA_W +: DATA_W]),
         .snap_clr     (accept),
         .snap_data    (snap_data[k]),
         .fresh        (fresh[k])
      );
   end

   // Next-cycle stream outputs are computed here and registered below, so
   // m_ready_i never reaches m_valid_o combinationally.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      osync_d = osync_o;
      data_d  = m_data_o;
      valid_d = m_valid_o;
      last_d  = m_last_o;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = HEADER;
               valid_d = 1'b1;
               last_d  = 1'b0;
               data_d  = DATA_W'({MAGIC, osync_o[15:0]});
            end
         end
         HEADER: begin
            if (m_ready_i) begin
               state_d = DATA;
               idx_d   = '0;
               data_d  = frame_buf[0];
               last_d  = 1'b0;
            end
         end
         DATA: begin
            if (m_ready_i) begin
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  osync_d = osync_o + 1'b1;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  data_d  = '0;
               end else begin
                  idx_d  = idx_q + 1'b1;
                  data_d = frame_buf[idx_d];
                  last_d = (idx_d == IDX_LAST);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         osync_o   <= '0;
         m_data_o  <= '0;
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
         busy_o    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         osync_o   <= osync_d;
         m_data_o  <= data_d;
         m_valid_o <= valid_d;
         m_last_o  <= last_d;
         busy_o    <= (state_d != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N_CH; k++) frame_buf[k] <= '0;
         stale_mask_o  <= '0;
         overrun_cnt_o <= '0;
      end else begin
         if (accept) begin
            for (int k = 0; k < N_CH; k++) frame_buf[k] <= snap_data[k];
            stale_mask_o <= ~(fresh | ch_valid_i);
         end
         if (trigger_i && (state_q != IDLE) && (overrun_cnt_o != 16'hFFFF))
            overrun_cnt_o <= overrun_cnt_o + 16'd1;
      end
   end

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Sequences the eight 32-bit measurement channels into one framed, flow-controlled word stream toward the PS/DMA path.
- Latches the latest sample of each channel on its strobe.
- Snapshots all channels on a frame trigger and emits a header word followed by N_CH data words over a valid/ready interface.
- Counts dropped triggers and exposes a completed-frame counter for the osync output.

Parameters:
N_CH, 8, number of channels per frame (2..16)
DATA_W, 32, channel and stream word width
MAGIC, 16'hA5A5, upper half of the header word

Ports:
clk  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  allows triggers to start frames
trigger_i  in  1  frame-start request, sampled each cycle
ch_data_i  in  N_CH*DATA_W  channel samples, channel k at bits [k*DATA_W +: DATA_W]
ch_valid_i  in  N_CH  per-channel sample strobe
m_data_o  out  DATA_W  stream word
m_valid_o  out  1  stream word valid
m_last_o  out  1  last word of frame
m_ready_i  in  1  downstream ready
osync_o  out  DATA_W  count of completed frames
busy_o  out  1  frame in progress
overrun_cnt_o  out  16  dropped-trigger count, saturating
stale_mask_o  out  N_CH  channels not refreshed for the current frame

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE; all hold/frame registers 0; fresh flags 0; m_valid_o=0, m_last_o=0, m_data_o=0, osync_o=0, busy_o=0, overrun_cnt_o=0, stale_mask_o=0. Reset mid-frame abandons the frame with no further output.
- Hold stage: ch_valid_i[k]=1 latches the channel-k slice into hold[k] and sets fresh[k]. Active in every state.
- FSM IDLE -> HEADER -> DATA -> IDLE.
- IDLE, trigger accepted when enable_i & trigger_i:
  - frame_buf[k] <= ch_valid_i[k] ? ch_data_i slice : hold[k] (same-cycle bypass).
  - stale_mask_o[k] <= ~(fresh[k] | ch_valid_i[k]).
  - All fresh flags clear; a same-cycle strobe does not count toward the next frame.
  - Go to HEADER.
- HEADER: m_valid_o=1, m_data_o={MAGIC, osync_o[15:0]} (DATA_W=32). On m_ready_i, go to DATA with idx=0.
- DATA: m_valid_o=1, m_data_o=frame_buf[idx], m_last_o=(idx==N_CH-1). Each handshake increments idx. The last handshake increments osync_o (32-bit wrap) and returns to IDLE.
- Latency: trigger accepted at cycle t -> header valid at t+1. With m_ready_i held high, the last word is at t+1+N_CH and IDLE is at t+2+N_CH, where a new trigger is accepted.
- Stream rule: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o stay stable. m_valid_o never drops before its handshake.
- Triggers outside IDLE: dropped; overrun_cnt_o increments, saturating at 16'hFFFF. A trigger in IDLE while enable_i=0 is ignored silently, no count.
- enable_i falling mid-frame: the frame completes normally, with no truncation.
- busy_o = (state != IDLE), registered with state.
- All outputs are registered; there is no combinational path from m_ready_i to m_valid_o.

Decomposition:
- Package frame_pkg: state enum (IDLE, HEADER, DATA), MAGIC constant, default N_CH/DATA_W, idx width as $clog2(N_CH).
- Sub-module channel_hold, one instance per channel: hold register plus fresh flag, with a snapshot-clear input and a bypassed-sample output.

Test Plan:
1. Reset then idle: all outputs 0, m_valid_o=0 for 100 cycles with no trigger.
2. ch_valid_i all set with data k*0x11111111, then trigger with m_ready_i=1 -> words A5A50000, then 00000000..77777777. m_last_o only on the 8th data word, osync_o=1 afterwards, stale_mask_o=00.
3. m_ready_i toggling 1-0-0-1 pseudo-randomly -> data and last stable while stalled, the same 9 words in order, no duplicates or drops.
4. Trigger again mid-frame three times -> overrun_cnt_o=3, frame content unchanged. Second frame header = A5A50001.
5. Only channel 2 strobed between frames, plus channel 5 strobed in the trigger cycle -> stale_mask_o=8'b1101_1011. Channel 5 word carries the same-cycle value.
6. rst_ni low during DATA idx=4 -> m_valid_o=0 immediately, state IDLE, counters 0. The next trigger yields header A5A50000.
